// File: rtl/register_file_writeback_pkg.sv
// Shared constants for the AVR register file: pointer pair locations and select/op encodings.
// Latency: none (constants only).
// Backpressure: none.
package register_file_writeback_pkg;

    localparam int X_LO = 26;
    localparam int Y_LO = 28;
    localparam int Z_LO = 30;

    localparam logic [1:0] PTR_SEL_X    = 2'b00;
    localparam logic [1:0] PTR_SEL_Y    = 2'b01;
    localparam logic [1:0] PTR_SEL_Z    = 2'b10;
    localparam logic [1:0] PTR_SEL_NONE = 2'b11;

    localparam logic [1:0] PTR_OP_HOLD     = 2'b00;
    localparam logic [1:0] PTR_OP_POST_INC = 2'b01;
    localparam logic [1:0] PTR_OP_PRE_DEC  = 2'b10;

    // True when the op modifies the pointer; 11 is an alias of hold.
    function automatic logic ptr_op_steps(input logic [1:0] op);
        return (op == PTR_OP_POST_INC) || (op == PTR_OP_PRE_DEC);
    endfunction

endpackage

// File: rtl/pointer_incdec.sv
// Pointer +/-1 unit: next pointer value and effective LD/ST address for the current op.
// Latency: purely combinational.
// Backpressure: none.
module pointer_incdec
    import register_file_writeback_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic [PW-1:0] ptr,
    input  logic [1:0]    op,
    output logic [PW-1:0] next_ptr,
    output logic [PW-1:0] eff_addr
);

    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;

    // Modular arithmetic gives the 0xFFFF <-> 0x0000 wrap with no flag.
    assign ptr_inc = ptr + PW'(1);
    assign ptr_dec = ptr - PW'(1);

    always_comb begin
        next_ptr = ptr;
        eff_addr = ptr;
        case (op)
            PTR_OP_POST_INC: next_ptr = ptr_inc;
            PTR_OP_PRE_DEC: begin
                next_ptr = ptr_dec;
                eff_addr = ptr_dec;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file_writeback.sv
// 32x8 AVR register file: byte/word write-back, two async read ports, X/Y/Z pointer unit.
// Latency: writes and pointer updates visible 1 cycle later; reads combinational (write-through if RF_WRITE_BYPASS_EN).
// Backpressure: none; every write and pointer op is accepted each cycle.
module register_file_writeback
    import register_file_writeback_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [ADDR_W-1:0]    rr_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [WIDTH-1:0]     rr_data,
    input  logic                 wr_en,
    input  logic                 wr_word,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic [1:0]           ptr_sel,
    input  logic [1:0]           ptr_op,
    output logic [2*WIDTH-1:0]   ptr_addr
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]  regs [NUM_REGS];

    logic [ADDR_W-1:0] wa_lo;
    logic [ADDR_W-1:0] wa_hi;
    logic [ADDR_W-1:0] ptr_lo_idx;
    logic [ADDR_W-1:0] ptr_hi_idx;
    logic              ptr_vld;
    logic [PW-1:0]     ptr_cur;
    logic [PW-1:0]     ptr_next;
    logic [PW-1:0]     ptr_eff;
    logic              ptr_conflict;
    logic              ptr_upd;

    // Word writes always land on an even/odd pair.
    assign wa_lo = wr_word ? {wr_addr[ADDR_W-1:1], 1'b0} : wr_addr;
    assign wa_hi = {wa_lo[ADDR_W-1:1], 1'b1};

    always_comb begin
        ptr_vld    = 1'b1;
        ptr_lo_idx = '0;
        ptr_cur    = '0;
        case (ptr_sel)
            PTR_SEL_X: begin
                ptr_lo_idx = ADDR_W'(X_LO);
                ptr_cur    = {regs[X_LO+1], regs[X_LO]};
            end
            PTR_SEL_Y: begin
                ptr_lo_idx = ADDR_W'(Y_LO);
                ptr_cur    = {regs[Y_LO+1], regs[Y_LO]};
            end
            PTR_SEL_Z: begin
                ptr_lo_idx = ADDR_W'(Z_LO);
                ptr_cur    = {regs[Z_LO+1], regs[Z_LO]};
            end
            default: ptr_vld = 1'b0;
        endcase
    end

    assign ptr_hi_idx = {ptr_lo_idx[ADDR_W-1:1], 1'b1};

    pointer_incdec #(
        .PW(PW)
    ) u_ptr (
        .ptr      (ptr_cur),
        .op       (ptr_op),
        .next_ptr (ptr_next),
        .eff_addr (ptr_eff)
    );

    assign ptr_addr = ptr_vld ? ptr_eff : '0;

    // Any write into the selected pair (byte or word) shares its pair index; the write then owns the pair.
    assign ptr_conflict = wr_en && (wa_lo[ADDR_W-1:1] == ptr_lo_idx[ADDR_W-1:1]);
    assign ptr_upd      = ptr_vld && ptr_op_steps(ptr_op) && !ptr_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ptr_upd) begin
                regs[ptr_lo_idx] <= ptr_next[WIDTH-1:0];
                regs[ptr_hi_idx] <= ptr_next[PW-1:WIDTH];
            end
            if (wr_en) begin
                regs[wa_lo] <= wr_data[WIDTH-1:0];
                if (wr_word) begin
                    regs[wa_hi] <= wr_data[PW-1:WIDTH];
                end
            end
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    // Write-through of register writes only; pointer updates still read the stored value.
    always_comb begin
        rd_data = regs[rd_addr];
        rr_data = regs[rr_addr];
        if (wr_en) begin
            if (rd_addr == wa_lo) begin
                rd_data = wr_data[WIDTH-1:0];
            end else if (wr_word && (rd_addr == wa_hi)) begin
                rd_data = wr_data[PW-1:WIDTH];
            end
            if (rr_addr == wa_lo) begin
                rr_data = wr_data[WIDTH-1:0];
            end else if (wr_word && (rr_addr == wa_hi)) begin
                rr_data = wr_data[PW-1:WIDTH];
            end
        end
    end
`else
    assign rd_data = regs[rd_addr];
    assign rr_data = regs[rr_addr];
`endif

endmodule

// File: tb/tb_register_file_writeback.sv
// Directed bench for register_file_writeback; expectations queued at drive time, popped at sample time.
module tb_register_file_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  rr_addr;
    logic [7:0]  rd_data;
    logic [7:0]  rr_data;
    logic        wr_en;
    logic        wr_word;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  ptr_sel;
    logic [1:0]  ptr_op;
    logic [15:0] ptr_addr;

    int checks   = 0;
    int failures = 0;

    string       exp_tag [$];
    logic [15:0] exp_val [$];

    register_file_writeback dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rr_addr  (rr_addr),
        .rd_data  (rd_data),
        .rr_data  (rr_data),
        .wr_en    (wr_en),
        .wr_word  (wr_word),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ptr_sel  (ptr_sel),
        .ptr_op   (ptr_op),
        .ptr_addr (ptr_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        string       tag;
        logic [15:0] e;
        checks++;
        if (exp_val.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            tag = exp_tag.pop_front();
            e   = exp_val.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h required=%h", tag, obs, e);
            end
        end
    endtask

    task automatic write(input logic word, input logic [4:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_word = word; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; wr_word = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [7:0] v);
        rd_addr = a;
        #1;
        expect_val(tag, {8'h00, v});
        check({8'h00, rd_data});
    endtask

    task automatic chk_rr(input string tag, input logic [4:0] a, input logic [7:0] v);
        rr_addr = a;
        #1;
        expect_val(tag, {8'h00, v});
        check({8'h00, rr_data});
    endtask

    task automatic chk_ptr(input string tag, input logic [15:0] v);
        #1;
        expect_val(tag, v);
        check(ptr_addr);
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; rr_addr = '0; wr_en = 1'b0; wr_word = 1'b0;
        wr_addr = '0; wr_data = '0; ptr_sel = 2'b00; ptr_op = 2'b00;
        tick();
        reset = 1'b0;
        chk_rd("reset_rd0", 5'd0, 8'h00);
        chk_ptr("reset_ptr_x", 16'h0000);

        // Reset clears a previously written register and the whole file
        write(1'b0, 5'd5, 16'h00A5);
        chk_rd("wr_r5", 5'd5, 8'hA5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_rd("reset_r5", 5'd5, 8'h00);
        for (int i = 0; i < 32; i++) begin
            chk_rr("reset_all", 5'(i), 8'h00);
        end

        // Reset dominates a same-cycle write and pointer op
        reset = 1'b1; ptr_sel = 2'b00; ptr_op = 2'b01;
        write(1'b0, 5'd6, 16'h00FF);
        reset = 1'b0; ptr_op = 2'b00;
        chk_rd("reset_dom_r6", 5'd6, 8'h00);
        chk_ptr("reset_dom_x", 16'h0000);

        // Byte and word writes
        write(1'b0, 5'd17, 16'h003C);
        chk_rr("byte_r17", 5'd17, 8'h3C);
        write(1'b1, 5'd3, 16'hBEEF);
        chk_rd("word_r2", 5'd2, 8'hEF);
        chk_rr("word_r3", 5'd3, 8'hBE);

        // Post-increment wraps X from 0xFFFF
        write(1'b1, 5'd26, 16'hFFFF);
        ptr_sel = 2'b00; ptr_op = 2'b01;
        chk_ptr("postinc_eff", 16'hFFFF);
        tick();
        ptr_op = 2'b00;
        chk_ptr("postinc_wrap", 16'h0000);
        chk_rd("postinc_r26", 5'd26, 8'h00);
        chk_rr("postinc_r27", 5'd27, 8'h00);

        // Pre-decrement on Z
        write(1'b1, 5'd30, 16'h0100);
        ptr_sel = 2'b10; ptr_op = 2'b10;
        chk_ptr("predec_eff", 16'h00FF);
        tick();
        ptr_op = 2'b00;
        chk_rd("predec_r31", 5'd31, 8'h00);
        chk_rr("predec_r30", 5'd30, 8'hFF);
        chk_ptr("predec_hold", 16'h00FF);

        // Pre-decrement wrap 0x0000 -> 0xFFFF
        write(1'b1, 5'd30, 16'h0000);
        ptr_op = 2'b10;
        chk_ptr("predec_wrap_eff", 16'hFFFF);
        tick();
        ptr_op = 2'b00;
        chk_ptr("predec_wrap", 16'hFFFF);

        // Write into the selected pair wins over the pointer update
        write(1'b1, 5'd28, 16'h1234);
        ptr_sel = 2'b01; ptr_op = 2'b01;
        write(1'b0, 5'd28, 16'h0077);
        ptr_op = 2'b00;
        chk_ptr("conflict_y", 16'h1277);

        // Write elsewhere and pointer update both complete
        write(1'b1, 5'd28, 16'h1234);
        ptr_op = 2'b01;
        write(1'b0, 5'd0, 16'h0042);
        ptr_op = 2'b00;
        chk_ptr("noconf_y", 16'h1235);
        chk_rd("noconf_r0", 5'd0, 8'h42);

        // Hold on op 11, and no effect with ptr_sel none
        ptr_op = 2'b11;
        tick();
        ptr_op = 2'b00;
        chk_ptr("op11_hold", 16'h1235);
        ptr_sel = 2'b11; ptr_op = 2'b10;
        chk_ptr("sel_none_eff", 16'h0000);
        tick();
        ptr_sel = 2'b01; ptr_op = 2'b00;
        chk_ptr("sel_none_y", 16'h1235);

        // Same-cycle read of a register being written
        write(1'b0, 5'd9, 16'h0011);
        wr_en = 1'b1; wr_word = 1'b0; wr_addr = 5'd9; wr_data = 16'h005A;
`ifdef RF_WRITE_BYPASS_EN
        chk_rd("bypass_r9", 5'd9, 8'h5A);
`else
        chk_rd("nobypass_r9", 5'd9, 8'h11);
`endif
        tick();
        wr_en = 1'b0;
        chk_rd("after_r9", 5'd9, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_writeback.md
Name: register_file_writeback

Overview:
- 32 x 8-bit AVR general-purpose register file.
- Consumes the write-back byte/word selected by the upstream 4-way source multiplexer (ALU, immediate, data memory, multiplier).
- Provides two combinational read ports (Rd, Rr) and an X/Y/Z pointer unit with post-increment and pre-decrement.
- Sits between the write-back select mux and the ALU/LD/ST address path.

Parameters:
- WIDTH, 8, register byte width.
- NUM_REGS, 32, number of registers; must be a power of two.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  ADDR_W  read port A address (Rd).
- rr_addr  input  ADDR_W  read port B address (Rr).
- rd_data  output  WIDTH  contents of R[rd_addr].
- rr_data  output  WIDTH  contents of R[rr_addr].
- wr_en  input  1  write enable.
- wr_word  input  1  1 = 16-bit pair write, 0 = byte write.
- wr_addr  input  ADDR_W  write destination; low register of the pair when wr_word=1.
- wr_data  input  2*WIDTH  write data; byte write uses [WIDTH-1:0].
- ptr_sel  input  2  pointer select: 00 X (R27:R26), 01 Y (R29:R28), 10 Z (R31:R30), 11 none.
- ptr_op  input  2  pointer operation: 00 hold, 01 post-increment, 10 pre-decrement, 11 hold.
- ptr_addr  output  2*WIDTH  effective data address for the current LD/ST.

Behaviour:
- Reset: on a clk edge with reset=1, all registers are cleared to 0x00.
  - Reset dominates wr_en and ptr_op issued in the same cycle.
  - Reset applied mid-sequence discards any pending update.
  - After reset: rd_data, rr_data and ptr_addr all read 0x00/0x0000.
- Reads are combinational from the register array, with zero latency.
  - Without the bypass feature, a read of a register written this cycle returns the old value.
- Byte write (wr_word=0): R[wr_addr] <= wr_data[7:0] on the edge; visible on the read ports the next cycle (1-cycle latency).
- Word write (wr_word=1): wr_addr[0] is forced to 0.
  - R[a] <= wr_data[7:0] and R[a+1] <= wr_data[15:0+8] on the same edge (i.e. wr_data[15:8] to R[a+1]).
  - Word writes are used by MOVW, ADIW/SBIW and MUL results to R1:R0.
- Pointer value P = {R[hi], R[lo]} for the selected pair.
- ptr_addr (combinational):
  - op hold or post-increment: ptr_addr = P.
  - op pre-decrement: ptr_addr = P - 1 (mod 2^16).
  - ptr_sel = 11: ptr_addr = 0x0000.
- Pointer update on the edge:
  - post-increment: P <= P + 1.
  - pre-decrement: P <= P - 1.
  - Both bytes update atomically in one cycle.
- Wrap-around: 0xFFFF + 1 = 0x0000 and 0x0000 - 1 = 0xFFFF; no flag is raised.
- Combination ptr_sel = 11 with op 01/10: no state change.
- Simultaneous register write and pointer update:
  - If the write touches either byte of the selected pair, the register write wins for the whole pair and the pointer update is dropped.
  - Writes to other registers and the pointer update both complete.
- wr_en=0 with a pointer op: only the pointer changes.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: when wr_en=1 and a read address matches a byte being written this cycle, the read port returns the incoming wr_data byte combinationally (write-through).
  - Pointer updates are not bypassed.
- Undefined: read ports always return stored contents (read-before-write).

Decomposition:
- Shared header/package holds:
  - constants X_LO=26, Y_LO=28, Z_LO=30;
  - PTR_SEL_X/Y/Z/NONE encodings;
  - PTR_OP_HOLD/POST_INC/PRE_DEC encodings.
- One sub-module: pointer_incdec.
  - 16-bit combinational ±1 unit producing the next pointer value and the effective address.
  - Instanced once, fed by a 4-way pair select using the existing multi-bit multiplexers.

Test Plan:
- Reset clears: write 0xA5 to R5, assert reset one cycle -> rd_addr=5 reads 0x00; all 32 registers read 0x00.
- Byte and word write: byte 0x3C to R17 -> rr_data=0x3C next cycle. Word 0xBEEF with wr_addr=3 -> R2=0xEF, R3=0xBE.
- Post-increment wrap: X=0xFFFF, ptr_op=01 -> ptr_addr=0xFFFF that cycle; next cycle X=0x0000, R26=R27=0x00.
- Pre-decrement: Z=0x0100, ptr_op=10 -> ptr_addr=0x00FF immediately; next cycle R31=0x00, R30=0xFF.
- Conflict:
  - Y=0x1234, ptr_op=01 with byte write 0x77 to R28 same cycle -> Y=0x1277 (write wins).
  - Same op with write to R0 -> Y=0x1235 and R0 updated.
- Bypass (RF_WRITE_BYPASS_EN defined): write 0x5A to R9 while rd_addr=9 -> rd_data=0x5A same cycle. Without the macro, the old value is returned.
